// File: rtl/upsample_pkg.sv
// Shared state encoding, mode constants and the 2x2 block packing rule for the
// upsample stream scheduler.
package upsample_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic MODE_REPL = 1'b0;
    localparam logic MODE_ZINS = 1'b1;

    // Word layout {p11, p10, p01, p00}: byte0 is the top-left output pixel.
    function automatic logic [31:0] pack_2x2(input logic mode, input logic [7:0] d);
        logic [31:0] w;
        w = {d, d, d, d};
        case (mode)
            MODE_REPL: w = {d, d, d, d};
            MODE_ZINS: w = {24'h0, d};
            default:   w = {d, d, d, d};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/upsample_obuf.sv
// Two-entry output FIFO holding packed 2x2 words; simultaneous push and pop allowed.
module upsample_obuf #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         vld_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] ent0_q, ent1_q;
    logic         wr_sel_q, rd_sel_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent0_q   <= '0;
            ent1_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                if (wr_sel_q) ent1_q <= din_i;
                else          ent0_q <= din_i;
                wr_sel_q <= ~wr_sel_q;
            end
            if (pop_i) rd_sel_q <= ~rd_sel_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign dout_o = rd_sel_q ? ent1_q : ent0_q;
    assign vld_o  = (cnt_q != 2'd0);
    assign occ_o  = cnt_q;

endmodule

// File: rtl/upsample_stream_sched.sv
// Frame sequencer: raster reads from the feature-map buffer, packs each pixel
// into a 2x2 block word and streams it out under valid/ready.
//   state | meaning
//   IDLE  | waiting for start; cfg_mode latched on accept
//   RUN   | issuing reads while output credit allows
//   DRAIN | all reads issued; waiting for the last word to handshake
//   DONE  | one-cycle done pulse, frame counter bumped
module upsample_stream_sched
    import upsample_pkg::*;
#(
    parameter int WI     = 32,
    parameter int WIDTH  = 128,
    parameter int HEIGHT = 128,
    parameter int ADDR_W = $clog2(WIDTH*HEIGHT)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              cfg_mode,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [WI-1:0]     out_din,
    output logic [15:0]       frame_cnt
);

    localparam int                NPIX      = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W:0]   LAST_WORD = (ADDR_W + 1)'(NPIX - 1);

    state_e            state_q;
    logic              mode_q;
    logic              busy_q;
    logic              done_q;
    logic              inflight_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W:0]   sent_cnt_q;
    logic [15:0]       frame_cnt_q;

    logic [1:0]    occ;
    logic          pop;
    logic          rd_en;
    logic [2:0]    credit_use;
    logic [WI-1:0] packed_word;

    assign pop = out_vld & out_rdy;
    // A word leaving this cycle frees its slot before the next read's data lands.
    assign credit_use  = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
    assign rd_en       = (state_q == RUN) && (credit_use < 3'd2);
    assign packed_word = WI'(pack_2x2(mode_q, mem_rd_data));

    upsample_obuf #(.W(WI)) u_obuf (
        .clk    (clk),
        .rstn   (rstn),
        .push_i (inflight_q),
        .din_i  (packed_word),
        .pop_i  (pop),
        .dout_o (out_din),
        .vld_o  (out_vld),
        .occ_o  (occ)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            mode_q      <= MODE_REPL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= 1'b0;
            rd_ptr_q    <= '0;
            sent_cnt_q  <= '0;
            frame_cnt_q <= 16'd0;
        end else begin
            inflight_q <= rd_en;
            done_q     <= 1'b0;
            if (pop) sent_cnt_q <= sent_cnt_q + (ADDR_W + 1)'(1);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q     <= cfg_mode;
                        rd_ptr_q   <= '0;
                        sent_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    if (rd_en) begin
                        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                        if (rd_ptr_q == LAST_ADDR) state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (sent_cnt_q == LAST_WORD)) begin
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_rd_en = rd_en;
    assign mem_addr  = rd_ptr_q;
    assign frame_cnt = frame_cnt_q;

endmodule
